// File: rtl/mem_arbiter.sv
// Two-port memory arbiter. The core (c_*) and loader/debug (d_*) ports share
// one memory port (m_*). Ties are broken round-robin, and any memory access
// that stalls too long is ended with err set.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    // core port
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdata_i,
    output logic [DW-1:0] c_rdata_o,
    output logic          c_ack_o,
    // loader/debug port
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_ack_o,
    // memory port
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic [DW-1:0] m_rdata_i,
    input  logic          m_ready_i,
    // status
    output logic          err_o,
    output logic          owner_o
);

    // state | meaning
    // IDLE  | no transaction; arbitrate pending requests
    // ISSUE | m_req high, waiting for m_ready or the wait limit
    // DONE  | one-cycle ack to the owner, err valid
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The wait limit never exceeds 255, so an 8-bit counter is enough.
    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT);

    state_t        state_q, state_d;
    logic [7:0]    wait_q, wait_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          winner;

    // Round-robin pick: a lone request wins; on a tie the side not served last wins.
    always_comb begin
        winner = 1'b0;
        if (c_req_i && d_req_i) begin
            winner = ~last_q;
        end else if (d_req_i) begin
            winner = 1'b1;
        end
    end

    // Next-state logic; the request fields are captured on the grant edge.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (c_req_i || d_req_i) begin
                    state_d = ISSUE;
                    wait_d  = 8'd0;
                    owner_d = winner;
                    last_d  = winner;
                    err_d   = 1'b0;
                    we_d    = winner ? d_we_i    : c_we_i;
                    addr_d  = winner ? d_addr_i  : c_addr_i;
                    wdata_d = winner ? d_wdata_i : c_wdata_i;
                end
            end
            ISSUE: begin
                // m_ready takes priority over an expiring wait counter.
                if (m_ready_i) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = m_rdata_i;
                        else         c_rdata_d = m_rdata_i;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        if (owner_q) d_rdata_d = '0;
                        else         c_rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; after reset the loader counts as last served so the core wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 8'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Outputs are decoded from the state so m_req and the acks drop as soon as reset asserts.
    always_comb begin
        m_req_o   = (state_q == ISSUE);
        c_ack_o   = (state_q == DONE) && !owner_q;
        d_ack_o   = (state_q == DONE) &&  owner_q;
        err_o     = (state_q == DONE) &&  err_q;
        m_we_o    = we_q;
        m_addr_o  = addr_q;
        m_wdata_o = wdata_q;
        owner_o   = owner_q;
        c_rdata_o = c_rdata_q;
        d_rdata_o = d_rdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a vector table, hand-written corner
// sequences, and random transactions checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, d_req, d_we;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic [DW-1:0] c_rdata, d_rdata;
    logic          c_ack, d_ack;
    logic          m_req, m_we, m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          err, owner;

    int n_pass = 0;
    int n_chk  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .c_req_i   (c_req),
        .c_we_i    (c_we),
        .c_addr_i  (c_addr),
        .c_wdata_i (c_wdata),
        .c_rdata_o (c_rdata),
        .c_ack_o   (c_ack),
        .d_req_i   (d_req),
        .d_we_i    (d_we),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_rdata_o (d_rdata),
        .d_ack_o   (d_ack),
        .m_req_o   (m_req),
        .m_we_o    (m_we),
        .m_addr_o  (m_addr),
        .m_wdata_o (m_wdata),
        .m_rdata_i (m_rdata),
        .m_ready_i (m_ready),
        .err_o     (err),
        .owner_o   (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c_req, c_we;
        logic [15:0] c_addr, c_wdata;
        logic        d_req, d_we;
        logic [15:0] d_addr, d_wdata;
        int          lat;       // ISSUE cycle index at which m_ready is raised
        logic [15:0] rdata;
        logic        exp_owner, exp_err;
        logic [15:0] exp_crd, exp_drd;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic vec_t mkv(input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
                                 input logic dr, input logic dw, input logic [15:0] da, input logic [15:0] dd,
                                 input int lat, input logic [15:0] rd, input logic eo, input logic ee,
                                 input logic [15:0] ecrd, input logic [15:0] edrd);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        v.lat = lat; v.rdata = rd;
        v.exp_owner = eo; v.exp_err = ee; v.exp_crd = ecrd; v.exp_drd = edrd;
        return v;
    endfunction

    // Called at a negedge while the DUT is in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic run_txn(input vec_t v);
        logic [15:0] a, wd;
        logic        w;
        logic        stable_ok;
        int          t, exp_t;
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        m_ready = 1'b0;
        @(negedge clk);
        a  = v.exp_owner ? v.d_addr  : v.c_addr;
        wd = v.exp_owner ? v.d_wdata : v.c_wdata;
        w  = v.exp_owner ? v.d_we    : v.c_we;
        chk("m_req_rise", m_req, 1'b1);
        chk("owner", owner, v.exp_owner);
        chk("m_addr", m_addr, a);
        chk("m_we", m_we, w);
        chk("m_wdata", m_wdata, wd);
        stable_ok = 1'b1;
        t = 0;
        while (!(c_ack || d_ack) && t < 40) begin
            if (!(m_req === 1'b1 && m_addr === a && m_we === w && m_wdata === wd && owner === v.exp_owner))
                stable_ok = 1'b0;
            m_ready = (t == v.lat);
            m_rdata = (t == v.lat) ? v.rdata : 16'($urandom);
            @(negedge clk);
            t++;
        end
        m_ready = 1'b0;
        exp_t = ((v.lat < TO) ? v.lat : TO) + 1;
        chk("issue_stable", stable_ok, 1'b1);
        chk("ack_delay", t, exp_t);
        chk("c_ack", c_ack, !v.exp_owner);
        chk("d_ack", d_ack, v.exp_owner);
        chk("err", err, v.exp_err);
        chk("m_req_done", m_req, 1'b0);
        chk("c_rdata", c_rdata, v.exp_crd);
        chk("d_rdata", d_rdata, v.exp_drd);
        if (v.exp_owner) d_req = 1'b0;
        else             c_req = 1'b0;
        @(negedge clk);
        chk("idle_quiet", {c_ack, d_ack, err, m_req}, 4'b0000);
    endtask

    initial begin
        vec_t        v;
        logic        m_last, win, we, e;
        logic [15:0] m_crd, m_drd;
        logic        pend_c, pend_d;

        tbl[0] = mkv(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000,  2, 16'hBEEF, 0, 0, 16'hBEEF, 16'h0000);
        tbl[1] = mkv(1, 0, 16'h0100, 16'h0000, 1, 0, 16'h0200, 16'h0000,  0, 16'h1111, 1, 0, 16'hBEEF, 16'h1111);
        tbl[2] = mkv(1, 0, 16'h0101, 16'h0000, 1, 0, 16'h0201, 16'h0000,  1, 16'h2222, 0, 0, 16'h2222, 16'h1111);
        tbl[3] = mkv(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0300, 16'h0000, 99, 16'hDEAD, 1, 1, 16'h2222, 16'h0000);
        tbl[4] = mkv(1, 0, 16'h0444, 16'h0000, 0, 0, 16'h0000, 16'h0000, 15, 16'h1234, 0, 0, 16'h1234, 16'h0000);
        tbl[5] = mkv(1, 1, 16'h0010, 16'h00AA, 0, 0, 16'h0000, 16'h0000,  3, 16'h9999, 0, 0, 16'h1234, 16'h0000);
        tbl[6] = mkv(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0020, 16'h0055, 16, 16'h8888, 1, 1, 16'h1234, 16'h0000);
        tbl[7] = mkv(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000, 14, 16'h5A5A, 1, 0, 16'h1234, 16'h5A5A);
        tbl[8] = mkv(1, 0, 16'h0031, 16'h0000, 1, 0, 16'h0032, 16'h0000,  0, 16'h0F0F, 0, 0, 16'h0F0F, 16'h5A5A);

        // reset values
        rst = 1'b1; m_ready = 1'b0; m_rdata = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ctrl", {m_req, m_we, c_ack, d_ack, err, owner}, 6'b0);
        chk("rst_m_addr", m_addr, 16'h0);
        chk("rst_m_wdata", m_wdata, 16'h0);
        chk("rst_rdata", {c_rdata, d_rdata}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(tbl[i]);

        // core write, loader read raised during the write's ISSUE
        c_req = 1; c_we = 1; c_addr = 16'h0010; c_wdata = 16'h00AA;
        d_req = 0; d_we = 0; d_addr = 16'h0300; d_wdata = 16'h0000;
        @(negedge clk);
        chk("wr_m_req", m_req, 1'b1);
        chk("wr_fields", {m_we, m_addr, m_wdata}, {1'b1, 16'h0010, 16'h00AA});
        d_req = 1;
        @(negedge clk);
        chk("wr_hold", {m_req, owner, m_addr}, {1'b1, 1'b0, 16'h0010});
        m_ready = 1; m_rdata = 16'h6666;
        @(negedge clk);
        m_ready = 0;
        chk("wr_ack", {c_ack, d_ack}, 2'b10);
        chk("wr_rdata_kept", c_rdata, 16'h0F0F);
        c_req = 0;
        @(negedge clk);
        chk("pend_gap", m_req, 1'b0);
        @(negedge clk);
        chk("pend_grant", {m_req, owner, m_we, m_addr}, {1'b1, 1'b1, 1'b0, 16'h0300});
        m_ready = 1; m_rdata = 16'h7777;
        @(negedge clk);
        m_ready = 0;
        chk("pend_ack", {c_ack, d_ack, err}, 3'b010);
        chk("pend_rdata", d_rdata, 16'h7777);
        d_req = 0;
        @(negedge clk);

        // requester drops req before its ack
        c_req = 1; c_we = 0; c_addr = 16'h0500;
        @(negedge clk);
        chk("drop_m_req", m_req, 1'b1);
        c_req = 0;
        @(negedge clk);
        @(negedge clk);
        m_ready = 1; m_rdata = 16'h4321;
        @(negedge clk);
        m_ready = 0;
        chk("drop_ack", {c_ack, d_ack, err}, 3'b100);
        chk("drop_rdata", c_rdata, 16'h4321);
        @(negedge clk);

        // random transactions against a transaction-level model
        m_last = 1'b0; m_crd = 16'h4321; m_drd = 16'h7777;
        pend_c = 1'b0; pend_d = 1'b0;
        for (int i = 0; i < 60; i++) begin
            v.c_req = pend_c | 1'($urandom_range(0, 1));
            v.d_req = pend_d | 1'($urandom_range(0, 1));
            if (!v.c_req && !v.d_req) begin
                if ($urandom_range(0, 1) == 1) v.c_req = 1'b1;
                else                           v.d_req = 1'b1;
            end
            v.c_we = 1'($urandom_range(0, 1)); v.d_we = 1'($urandom_range(0, 1));
            v.c_addr = 16'($urandom); v.d_addr = 16'($urandom);
            v.c_wdata = 16'($urandom); v.d_wdata = 16'($urandom);
            v.lat = $urandom_range(0, 20);
            v.rdata = 16'($urandom);
            win = (v.c_req && v.d_req) ? !m_last : v.d_req;
            e   = (v.lat > TO);
            we  = win ? v.d_we : v.c_we;
            if (!we) begin
                if (win) m_drd = e ? 16'h0000 : v.rdata;
                else     m_crd = e ? 16'h0000 : v.rdata;
            end
            m_last = win;
            v.exp_owner = win; v.exp_err = e; v.exp_crd = m_crd; v.exp_drd = m_drd;
            run_txn(v);
            pend_c = win ? v.c_req : 1'b0;
            pend_d = win ? 1'b0 : v.d_req;
        end

        // reset in the middle of ISSUE
        c_req = 1; c_we = 0; c_addr = 16'h0777; d_req = 0;
        @(negedge clk);
        chk("mid_m_req", m_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {m_req, m_we, c_ack, d_ack, err, owner}, 6'b0);
        chk("mid_rst_addr", m_addr, 16'h0);
        chk("mid_rst_rdata", {c_rdata, d_rdata}, 32'h0);
        m_ready = 1; m_rdata = 16'hFFFF;
        @(negedge clk);
        m_ready = 0;
        chk("mid_rst_noack", {c_ack, d_ack, m_req}, 3'b000);
        rst = 1'b0; c_req = 0;
        run_txn(mkv(1, 0, 16'h0A0A, 16'h0000, 1, 0, 16'h0B0B, 16'h0000, 4, 16'hCAFE, 0, 0, 16'hCAFE, 16'h0000));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, meaning address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for m_ready (range 1..255).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 c_req  input  1  core request, held high until c_ack.
REQ-007 c_we  input  1  core write enable (1 = write, 0 = read).
REQ-008 c_addr  input  AW  core address.
REQ-009 c_wdata  input  DW  core write data.
REQ-010 c_rdata  output  DW  core read data, valid while c_ack is high.
REQ-011 c_ack  output  1  core completion pulse, one cycle wide.
REQ-012 d_req, d_we, d_addr, d_wdata, d_rdata, d_ack  same directions and widths as the c_* ports  loader/debug port.
REQ-013 m_req  output  1  memory request.
REQ-014 m_we  output  1  memory write enable.
REQ-015 m_addr  output  AW  memory address.
REQ-016 m_wdata  output  DW  memory write data.
REQ-017 m_rdata  input  DW  memory read data, valid when m_ready is high.
REQ-018 m_ready  input  1  memory completion.
REQ-019 err  output  1  timeout flag; high together with the ack of a timed-out transaction.
REQ-020 owner  output  1  identifies the requester being served (0 = core, 1 = loader); valid outside IDLE.

Function
REQ-021 The FSM SHALL have three states: IDLE, ISSUE and DONE.
REQ-022 IDLE->ISSUE SHALL occur when c_req or d_req is high.
  - On that edge the winner's we/addr/wdata SHALL be registered into m_we/m_addr/m_wdata.
  - owner SHALL be set to the winner.
REQ-023 Arbitration SHALL be round-robin.
  - A single request always wins.
  - On a tie, the requester not served last SHALL win.
  - The last-served pointer SHALL update on each IDLE->ISSUE transition.
REQ-024 In ISSUE, m_req SHALL be high and the m_* outputs SHALL stay stable until the state is left.
REQ-025 ISSUE->DONE on m_ready high: m_rdata SHALL be captured into the owner's rdata register, with err=0.
REQ-026 Wait counter behaviour:
  - A wait counter SHALL clear on entry to ISSUE.
  - It SHALL increment each ISSUE cycle with m_ready low.
  - When the counter equals TIMEOUT with m_ready low, the state SHALL go ISSUE->DONE with err=1 and rdata=0.
REQ-027 If m_ready is high in the same cycle the counter reaches TIMEOUT, m_ready SHALL win (normal completion, err=0).
REQ-028 DONE SHALL last exactly one cycle.
  - The owner's ack SHALL be high and err SHALL be valid.
  - m_req SHALL be low.
  - The next state SHALL be IDLE unconditionally.
REQ-029 The non-owner ack SHALL stay low at all times; c_ack and d_ack SHALL never be high together.
REQ-030 Latency:
  - req first high in IDLE at cycle N -> m_req high from cycle N+1.
  - m_ready high at cycle M -> ack high at cycle M+1.
  - The earliest next grant is at cycle M+2.
REQ-031 Writes SHALL assert m_we=1 in ISSUE, and rdata SHALL be unchanged on a write completion.
REQ-032 If a requester drops req before its ack, the transaction SHALL still complete and the ack SHALL still be issued.
REQ-033 A request from the non-owner arriving during ISSUE/DONE SHALL be held pending and arbitrated in the next IDLE.
REQ-034 rdata registers SHALL hold their last captured value until the next read completion for that port.

Reset
REQ-035 On rst high, the block SHALL asynchronously enter IDLE.
REQ-036 During reset, the following SHALL be 0: m_req, m_we, m_addr, m_wdata, c_ack, d_ack, err, owner, c_rdata, d_rdata and the wait counter.
REQ-037 After reset, the last-served pointer SHALL be set to loader, so the core wins the first tie.
REQ-038 A reset asserted mid-transaction SHALL abort it with no ack; m_req SHALL drop immediately.

Verification
REQ-039 Core read, single request:
  - Stimulus: c_req=1, c_addr=0x0040; m_ready=1 two cycles after m_req rises, with m_rdata=0xBEEF.
  - Response: c_ack for one cycle with c_rdata=0xBEEF and err=0.
REQ-040 Tie after reset:
  - Stimulus: c_req=d_req=1 held.
  - Response: grants alternate core, loader, core, and each ack is followed by the other port's m_req 2 cycles later.
REQ-041 Timeout:
  - Stimulus: d_req=1 read, m_ready held 0.
  - Response: after 15 wait cycles, d_ack=1 with err=1 and d_rdata=0x0000; then IDLE.
REQ-042 Ready at the timeout boundary:
  - Stimulus: m_ready=1 exactly on the cycle the counter reaches TIMEOUT, with m_rdata=0x1234.
  - Response: ack with err=0 and rdata=0x1234.
REQ-043 Write with a pending read:
  - Stimulus: core write addr 0x0010, data 0x00AA; during the core's ISSUE, d_req read is raised.
  - Response: m_we=1 with m_addr=0x0010 and m_wdata=0x00AA; then the loader read is served.
REQ-044 Reset mid-operation:
  - Stimulus: rst pulsed during ISSUE.
  - Response: m_req=0 immediately, no ack, and all outputs 0.
